alu_issue_arbiter: RTL

- Shares one combinational ALU among NUM_REQ requesters, e.g. the integer execute path and the address/branch unit.
- Accepts requests over valid/ready, picks one round-robin and registers its operands.
- Holds those operands on the ALU for the required number of cycles, then returns a registered result tagged with the requester ID.
- The ALU is instantiated beside this block and connected through the alu_* ports.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/alu_issue_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode and arbiter state definitions.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    MUL = 4'd2,
    AND = 4'd3,
    OR  = 4'd4,
    XOR = 4'd5,
    NOT = 4'd6,
    SLL = 4'd7,
    SRL = 4'd8
  } alu_op_e;

  // Highest defined opcode; anything above is an illegal select.
  localparam logic [3:0] ALU_OP_LAST = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  int   cand_s;
  logic found_s;

  // Scan from ptr upward modulo NUM_REQ and keep the first hit.
  always_comb begin
    cand_s    = 0;
    found_s   = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = (int'(ptr) + i) % NUM_REQ;
      if (!found_s && req[cand_s]) begin
        found_s   = 1'b1;
        grant_idx = IDX_W'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      grant[grant_idx] = 1'b1;
    end else begin
      grant = '0;
    end
    grant_valid = found_s;
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of NUM_REQ requesters onto one shared combinational ALU.
// Optional ALU_ILLEGAL_OP_EN: adds resp_err and short-circuits illegal selects.
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int dataWidth   = 32,
  parameter int selectWidth = 4,
  parameter int NUM_REQ     = 2,
  parameter int MUL_CYCLES  = 2,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*dataWidth-1:0]   req_a,
  input  logic [NUM_REQ*dataWidth-1:0]   req_b,
  input  logic [NUM_REQ*selectWidth-1:0] req_sel,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [IDX_W-1:0]               resp_id,
  output logic [dataWidth-1:0]           resp_lo,
  output logic [dataWidth-1:0]           resp_hi,
`ifdef ALU_ILLEGAL_OP_EN
  output logic                           resp_err,
`endif
  output logic [dataWidth-1:0]           alu_a,
  output logic [dataWidth-1:0]           alu_b,
  output logic [selectWidth-1:0]         alu_sel,
  input  logic [dataWidth-1:0]           alu_out,
  input  logic [dataWidth-1:0]           alu_out_high
);

  localparam int                     CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [selectWidth-1:0] SEL_ADD  = selectWidth'(ADD);
  localparam logic [selectWidth-1:0] SEL_MUL  = selectWidth'(MUL);
  localparam logic [selectWidth-1:0] SEL_LAST = selectWidth'(ALU_OP_LAST);
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]       MUL_CNT  = CNT_W'(MUL_CYCLES - 1);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [dataWidth-1:0]   a_q, a_d, b_q, b_d;
  logic [selectWidth-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [IDX_W-1:0]       resp_id_q, resp_id_d;
  logic [dataWidth-1:0]   resp_lo_q, resp_lo_d, resp_hi_q, resp_hi_d;
`ifdef ALU_ILLEGAL_OP_EN
  logic                   resp_err_q, resp_err_d;
`endif

  logic [NUM_REQ-1:0]     grant_s;
  logic [IDX_W-1:0]       grant_idx_s;
  logic                   grant_valid_s;
  logic [dataWidth-1:0]   g_a_s, g_b_s;
  logic [selectWidth-1:0] g_sel_s;
  logic                   g_illegal_s;
  logic                   exec_illegal_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req         (req_valid),
    .ptr         (rr_ptr_q),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  assign g_a_s          = req_a[int'(grant_idx_s)*dataWidth +: dataWidth];
  assign g_b_s          = req_b[int'(grant_idx_s)*dataWidth +: dataWidth];
  assign g_sel_s        = req_sel[int'(grant_idx_s)*selectWidth +: selectWidth];
  assign g_illegal_s    = (g_sel_s > SEL_LAST);
  assign exec_illegal_s = (sel_q > SEL_LAST);

  // Next-state and datapath; req_ready is the only combinational output.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    a_d          = a_q;
    b_d          = b_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_lo_d    = resp_lo_q;
    resp_hi_d    = resp_hi_q;
`ifdef ALU_ILLEGAL_OP_EN
    resp_err_d   = resp_err_q;
`endif
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          req_ready = grant_s;
          rr_ptr_d  = (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + IDX_W'(1);
          resp_id_d = grant_idx_s;
          a_d       = g_a_s;
          b_d       = g_b_s;
          sel_d     = g_sel_s;
          cnt_d     = (g_sel_s == SEL_MUL) ? MUL_CNT : '0;
          state_d   = EXEC;
`ifdef ALU_ILLEGAL_OP_EN
          resp_err_d = 1'b0;
          // Illegal selects never reach the ALU and skip EXEC entirely.
          if (g_illegal_s) begin
            sel_d        = SEL_ADD;
            resp_lo_d    = '0;
            resp_hi_d    = '0;
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            resp_err_d = 1'b0;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          resp_lo_d    = exec_illegal_s ? '0 : alu_out;
          resp_hi_d    = (sel_q == SEL_MUL) ? alu_out_high : '0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= SEL_ADD;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_lo_q    <= '0;
      resp_hi_q    <= '0;
`ifdef ALU_ILLEGAL_OP_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_lo_q    <= resp_lo_d;
      resp_hi_q    <= resp_hi_d;
`ifdef ALU_ILLEGAL_OP_EN
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_lo    = resp_lo_q;
  assign resp_hi    = resp_hi_q;
`ifdef ALU_ILLEGAL_OP_EN
  assign resp_err   = resp_err_q;
`endif
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = sel_q;

endmodule
